// File: rtl/tagged_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tagged_queue_pkg
// Description : Shared defaults, entry layout and count-width helper for the
//               tagged queue slice.
// Revision    : 1.0 - initial release
// ============================================================================
package tagged_queue_pkg;

    localparam int TQ_DEPTH  = 4;
    localparam int TQ_DATA_W = 8;
    localparam int TQ_TAG_W  = 2;

    typedef struct packed {
        logic [TQ_TAG_W-1:0]  tag;
        logic [TQ_DATA_W-1:0] data;
    } tq_entry_t;

    // Occupancy runs 0..DEPTH inclusive, so one bit wider than a pointer.
    function automatic int tq_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : tagged_queue_pkg
`default_nettype wire

// File: rtl/tagged_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : tagged_queue_if
// Description : Enqueue/dequeue handshake bundle for tagged_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface tagged_queue_if
    import tagged_queue_pkg::*;
#(
    parameter int DATA_W = TQ_DATA_W,
    parameter int TAG_W  = TQ_TAG_W,
    parameter int CNT_W  = tq_count_w(TQ_DEPTH)
);
    logic              io_enq_valid;
    logic              io_enq_ready;
    logic [DATA_W-1:0] io_enq_bits_data;
    logic [TAG_W-1:0]  io_enq_bits_tag;
    logic              io_deq_valid;
    logic              io_deq_ready;
    logic [DATA_W-1:0] io_deq_bits_data;
    logic [TAG_W-1:0]  io_deq_bits_tag;
    logic [CNT_W-1:0]  io_count;

    // Environment side: produces enqueues, consumes dequeues.
    modport master (
        output io_enq_valid, io_enq_bits_data, io_enq_bits_tag, io_deq_ready,
        input  io_enq_ready, io_deq_valid, io_deq_bits_data, io_deq_bits_tag,
        input  io_count
    );

    // Queue side.
    modport slave (
        input  io_enq_valid, io_enq_bits_data, io_enq_bits_tag, io_deq_ready,
        output io_enq_ready, io_deq_valid, io_deq_bits_data, io_deq_bits_tag,
        output io_count
    );
endinterface : tagged_queue_if
`default_nettype wire

// File: rtl/tagged_queue_ram.sv
`default_nettype none
// ============================================================================
// Module      : tagged_queue_ram
// Description : Entry storage, one write port and one asynchronous read port,
//               no reset. Isolated so it can be swapped for an SRAM macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tagged_queue_ram
    import tagged_queue_pkg::*;
#(
    parameter int DEPTH  = TQ_DEPTH,
    parameter int WIDTH  = TQ_TAG_W + TQ_DATA_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : tagged_queue_ram
`default_nettype wire

// File: rtl/tagged_queue.sv
`default_nettype none
// ============================================================================
// Module      : tagged_queue
// Description : FIFO capturing {tag,data} behind the round-robin arbiter.
//               enq_ready is registered-state only to cut the ready chain.
//               Optional zero-latency flow-through: TAGGED_QUEUE_FLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tagged_queue
    import tagged_queue_pkg::*;
#(
    parameter int DEPTH  = TQ_DEPTH,
    parameter int DATA_W = TQ_DATA_W,
    parameter int TAG_W  = TQ_TAG_W
) (
    input  logic          clk,
    input  logic          reset,
    tagged_queue_if.slave q
);
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = tq_count_w(DEPTH);
    localparam int c_ENTRY_W = TAG_W + DATA_W;

    logic [c_PTR_W-1:0]   r_enq_ptr;
    logic [c_PTR_W-1:0]   r_deq_ptr;
    logic                 r_maybe_full;

    logic                 w_ptr_match;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_do_enq;
    logic                 w_do_deq;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;
    logic [c_PTR_W-1:0]   w_ptr_diff;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_ENTRY_W-1:0] w_wr_data;
    logic [c_ENTRY_W-1:0] w_rd_data;
    logic [DATA_W-1:0]    w_head_data;
    logic [TAG_W-1:0]     w_head_tag;

    assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
    assign w_empty     = w_ptr_match & ~r_maybe_full;
    assign w_full      = w_ptr_match &  r_maybe_full;

    assign q.io_enq_ready = ~w_full;
    assign w_do_enq       = q.io_enq_valid & q.io_enq_ready;
    assign w_do_deq       = q.io_deq_valid & q.io_deq_ready;

    assign w_head_tag  = w_rd_data[c_ENTRY_W-1 -: TAG_W];
    assign w_head_data = w_rd_data[DATA_W-1:0];

`ifdef TAGGED_QUEUE_FLOW_EN
    // When empty the producer's entry is presented directly; if taken, it
    // never touches storage or state.
    assign w_bypass           = w_empty & w_do_deq;
    assign q.io_deq_valid     = ~w_empty | q.io_enq_valid;
    assign q.io_deq_bits_data = w_empty ? q.io_enq_bits_data : w_head_data;
    assign q.io_deq_bits_tag  = w_empty ? q.io_enq_bits_tag  : w_head_tag;
`else
    assign w_bypass           = 1'b0;
    assign q.io_deq_valid     = ~w_empty;
    assign q.io_deq_bits_data = w_head_data;
    assign q.io_deq_bits_tag  = w_head_tag;
`endif

    assign w_push    = w_do_enq & ~w_bypass;
    assign w_pop     = w_do_deq & ~w_bypass;
    assign w_wr_data = {q.io_enq_bits_tag, q.io_enq_bits_data};

    tagged_queue_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (c_ENTRY_W),
        .ADDR_W (c_PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_enq_ptr),
        .wr_data (w_wr_data),
        .rd_addr (r_deq_ptr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enq_ptr    <= '0;
            r_deq_ptr    <= '0;
            r_maybe_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_enq_ptr <= r_enq_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_deq_ptr <= r_deq_ptr + c_PTR_W'(1);
            end
            // Equal pointers are disambiguated by the direction of the last
            // unbalanced move.
            if (w_push != w_pop) begin
                r_maybe_full <= w_push;
            end
        end
    end

    assign w_ptr_diff = r_enq_ptr - r_deq_ptr;

    always_comb begin
        w_count = '0;
        if (w_ptr_match) begin
            w_count = r_maybe_full ? c_CNT_W'(DEPTH) : '0;
        end else begin
            w_count = {1'b0, w_ptr_diff};
        end
    end

    assign q.io_count = w_count;

endmodule : tagged_queue
`default_nettype wire

// File: tb/tb_tagged_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_tagged_queue
// Description : Self-checking bench: vector table plus scoreboard for data
//               order, and hand sequences for reset and latency corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tagged_queue;
    import tagged_queue_pkg::*;

    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = tq_count_w(c_DEPTH);

    typedef struct {
        logic       ev;
        logic [7:0] d;
        logic [1:0] t;
        logic       dr;
        logic       er;
        logic       dv;
        int         cnt;
    } vec_t;

    logic clk;
    logic reset;

    tagged_queue_if #(.DATA_W(8), .TAG_W(2), .CNT_W(c_CNT_W)) bus ();

    tagged_queue #(
        .DEPTH  (c_DEPTH),
        .DATA_W (8),
        .TAG_W  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_checks = 0;
    int        n_pass   = 0;
    vec_t      vecs[$];
    tq_entry_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic void add_vec(input logic ev, input logic [7:0] d,
                                    input logic [1:0] t, input logic dr,
                                    input logic er, input logic dv,
                                    input int cnt);
        vec_t v;
        v.ev = ev; v.d = d; v.t = t; v.dr = dr;
        v.er = er; v.dv = dv; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic ev, input logic [7:0] d,
                         input logic [1:0] t, input logic dr);
        bus.io_enq_valid     = ev;
        bus.io_enq_bits_data = d;
        bus.io_enq_bits_tag  = t;
        bus.io_deq_ready     = dr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector, check pre-edge outputs, score any dequeue, advance.
    task automatic apply(input vec_t v, input int idx);
        logic      exp_dv;
        tq_entry_t e;
        drive(v.ev, v.d, v.t, v.dr);
        #1;
        exp_dv = v.dv;
`ifdef TAGGED_QUEUE_FLOW_EN
        if (v.cnt == 0 && v.ev) exp_dv = 1'b1;
`endif
        check($sformatf("v%0d enq_ready", idx), int'(bus.io_enq_ready), int'(v.er));
        check($sformatf("v%0d deq_valid", idx), int'(bus.io_deq_valid), int'(exp_dv));
        check($sformatf("v%0d count", idx), int'(bus.io_count), v.cnt);
        if (v.ev && v.er) sb.push_back('{tag: v.t, data: v.d});
        if (v.dr && exp_dv) begin
            if (sb.size() == 0) begin
                check($sformatf("v%0d scoreboard_nonempty", idx), 0, 1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d deq_data", idx), int'(bus.io_deq_bits_data), int'(e.data));
                check($sformatf("v%0d deq_tag", idx), int'(bus.io_deq_bits_tag), int'(e.tag));
            end
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 2'd0, 1'b0);

        // Reset held across several edges keeps the idle state.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst%0d enq_ready", i), int'(bus.io_enq_ready), 1);
            check($sformatf("rst%0d deq_valid", i), int'(bus.io_deq_valid), 0);
            check($sformatf("rst%0d count", i), int'(bus.io_count), 0);
        end
        reset = 1'b0;

        // Fill, refuse when full, full+deq, then drain.
        add_vec(0, 8'h00, 0, 0, 1, 0, 0);
        add_vec(1, 8'h11, 0, 0, 1, 0, 0);
        add_vec(1, 8'h22, 1, 0, 1, 1, 1);
        add_vec(1, 8'h33, 2, 0, 1, 1, 2);
        add_vec(1, 8'h44, 3, 0, 1, 1, 3);
        add_vec(1, 8'h55, 0, 0, 0, 1, 4);
        add_vec(1, 8'h55, 0, 1, 0, 1, 4);
        add_vec(0, 8'h00, 0, 0, 1, 1, 3);
        add_vec(0, 8'h00, 0, 1, 1, 1, 3);
        add_vec(0, 8'h00, 0, 1, 1, 1, 2);
        add_vec(0, 8'h00, 0, 1, 1, 1, 1);
        add_vec(0, 8'h00, 0, 0, 1, 0, 0);
        // Hold two entries, then stream ten through across pointer wrap.
        add_vec(1, 8'hA0, 0, 0, 1, 0, 0);
        add_vec(1, 8'hA1, 1, 0, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            add_vec(1, 8'hB0 + 8'(i), 2'(i), 1, 1, 1, 2);
        end
        add_vec(0, 8'h00, 0, 1, 1, 1, 2);
        add_vec(0, 8'h00, 0, 1, 1, 1, 1);
        add_vec(0, 8'h00, 0, 0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset mid-stream with three entries held.
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v.ev = 1; v.d = 8'hC0 + 8'(i); v.t = 2'(i); v.dr = 0;
            v.er = 1; v.dv = (i != 0); v.cnt = i;
            apply(v, 100 + i);
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst pre count", int'(bus.io_count), 3);
        step();
        reset = 1'b0;
        sb.delete();
        #1;
        check("mid_rst count", int'(bus.io_count), 0);
        check("mid_rst deq_valid", int'(bus.io_deq_valid), 0);
        check("mid_rst enq_ready", int'(bus.io_enq_ready), 1);
        drive(1'b1, 8'hA5, 2'd1, 1'b0);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b1);
        #1;
        check("post_rst deq_valid", int'(bus.io_deq_valid), 1);
        check("post_rst deq_data", int'(bus.io_deq_bits_data), 'hA5);
        check("post_rst deq_tag", int'(bus.io_deq_bits_tag), 1);
        step();
        check("post_rst drained count", int'(bus.io_count), 0);
        check("post_rst drained deq_valid", int'(bus.io_deq_valid), 0);

        // Empty queue, enqueue with consumer ready: latency depends on build.
        drive(1'b1, 8'h7E, 2'd3, 1'b1);
        #1;
`ifdef TAGGED_QUEUE_FLOW_EN
        check("flow same-cycle deq_valid", int'(bus.io_deq_valid), 1);
        check("flow same-cycle data", int'(bus.io_deq_bits_data), 'h7E);
        check("flow same-cycle tag", int'(bus.io_deq_bits_tag), 3);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b1);
        #1;
        check("flow after count", int'(bus.io_count), 0);
        check("flow after deq_valid", int'(bus.io_deq_valid), 0);
`else
        check("lat same-cycle deq_valid", int'(bus.io_deq_valid), 0);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b1);
        #1;
        check("lat next count", int'(bus.io_count), 1);
        check("lat next deq_valid", int'(bus.io_deq_valid), 1);
        check("lat next data", int'(bus.io_deq_bits_data), 'h7E);
        check("lat next tag", int'(bus.io_deq_bits_tag), 3);
        step();
        check("lat drained count", int'(bus.io_count), 0);
`endif
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tagged_queue
`default_nettype wire
